// File: rtl/arm_exec_unit.sv
// arm_exec_unit: decode/execute datapath for the ARMv4-style core.
// Instruction fields are latched on decode_en. Operand 2 passes through a
// barrel shifter, and the ALU produces the result and NZCV from the latched
// fields, the register values supplied by the CPU and the current flags.
module arm_exec_unit (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        decode_en,
   input  logic [31:0] instruction,
   input  logic [31:0] rn_data,
   input  logic [31:0] rm_data,
   input  logic [31:0] rs_data,
   input  logic [3:0]  flags_in,
   output logic        valid,
   output logic [3:0]  opcode,
   output logic [3:0]  rd,
   output logic [3:0]  rn,
   output logic [3:0]  rm,
   output logic [3:0]  rs,
   output logic        s_bit,
   output logic        is_dp,
   output logic        is_ls,
   output logic        is_branch,
   output logic        is_load,
   output logic        is_byte,
   output logic        pre_index,
   output logic        add_offset,
   output logic        write_back,
   output logic [11:0] offset_12,
   output logic        branch_link,
   output logic [23:0] imm24,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] result,
   output logic        rd_we,
   output logic [3:0]  flags_out,
   output logic        flags_we
);

   // Shift type encodings from ir[6:5]
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // ---------------------------------------------------------------------
   // Decoder field registers
   // ---------------------------------------------------------------------
   logic        valid_q,      valid_d;
   logic [2:0]  cls_q,        cls_d;        // ir[27:25]
   logic [3:0]  opcode_q,     opcode_d;
   logic        s_bit_q,      s_bit_d;
   logic [3:0]  rn_q,         rn_d;
   logic [3:0]  rd_q,         rd_d;
   logic [3:0]  rs_q,         rs_d;
   logic [3:0]  rm_q,         rm_d;
   logic [7:0]  sh_ctl_q,     sh_ctl_d;     // ir[11:4]: amount, type, reg-shift bit
   logic        is_load_q,    is_load_d;
   logic        is_byte_q,    is_byte_d;
   logic        pre_index_q,  pre_index_d;
   logic        add_offset_q, add_offset_d;
   logic        write_back_q, write_back_d;
   logic [11:0] offset_12_q,  offset_12_d;
   logic        link_q,       link_d;
   logic [23:0] imm24_q,      imm24_d;

   logic in_is_ls;
   logic in_is_br;

   assign in_is_ls = (instruction[27:26] == 2'b01);
   assign in_is_br = (instruction[27:25] == 3'b101);

   // Next-state for the decoder: load on decode_en, otherwise hold fields.
   // Load/store and branch fields are zeroed for other classes so they never
   // carry stray bits from unrelated encodings.
   always_comb begin
      valid_d      = decode_en;
      cls_d        = cls_q;
      opcode_d     = opcode_q;
      s_bit_d      = s_bit_q;
      rn_d         = rn_q;
      rd_d         = rd_q;
      rs_d         = rs_q;
      rm_d         = rm_q;
      sh_ctl_d     = sh_ctl_q;
      is_load_d    = is_load_q;
      is_byte_d    = is_byte_q;
      pre_index_d  = pre_index_q;
      add_offset_d = add_offset_q;
      write_back_d = write_back_q;
      offset_12_d  = offset_12_q;
      link_d       = link_q;
      imm24_d      = imm24_q;
      if (decode_en) begin
         cls_d        = instruction[27:25];
         opcode_d     = instruction[24:21];
         s_bit_d      = instruction[20];
         rn_d         = instruction[19:16];
         rd_d         = instruction[15:12];
         rs_d         = instruction[11:8];
         rm_d         = instruction[3:0];
         sh_ctl_d     = instruction[11:4];
         pre_index_d  = in_is_ls & instruction[24];
         add_offset_d = in_is_ls & instruction[23];
         is_byte_d    = in_is_ls & instruction[22];
         write_back_d = in_is_ls & instruction[21];
         is_load_d    = in_is_ls & instruction[20];
         offset_12_d  = in_is_ls ? instruction[11:0] : 12'd0;
         link_d       = in_is_br & instruction[24];
         imm24_d      = in_is_br ? instruction[23:0] : 24'd0;
      end
   end

   // Decoder state register with asynchronous active-low clear
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         valid_q      <= 1'b0;
         cls_q        <= 3'd0;
         opcode_q     <= 4'd0;
         s_bit_q      <= 1'b0;
         rn_q         <= 4'd0;
         rd_q         <= 4'd0;
         rs_q         <= 4'd0;
         rm_q         <= 4'd0;
         sh_ctl_q     <= 8'd0;
         is_load_q    <= 1'b0;
         is_byte_q    <= 1'b0;
         pre_index_q  <= 1'b0;
         add_offset_q <= 1'b0;
         write_back_q <= 1'b0;
         offset_12_q  <= 12'd0;
         link_q       <= 1'b0;
         imm24_q      <= 24'd0;
      end else begin
         valid_q      <= valid_d;
         cls_q        <= cls_d;
         opcode_q     <= opcode_d;
         s_bit_q      <= s_bit_d;
         rn_q         <= rn_d;
         rd_q         <= rd_d;
         rs_q         <= rs_d;
         rm_q         <= rm_d;
         sh_ctl_q     <= sh_ctl_d;
         is_load_q    <= is_load_d;
         is_byte_q    <= is_byte_d;
         pre_index_q  <= pre_index_d;
         add_offset_q <= add_offset_d;
         write_back_q <= write_back_d;
         offset_12_q  <= offset_12_d;
         link_q       <= link_d;
         imm24_q      <= imm24_d;
      end
   end

   // ---------------------------------------------------------------------
   // Class decode and field outputs
   // ---------------------------------------------------------------------
   logic dp_cls;
   logic ls_cls;
   logic br_cls;

   assign dp_cls = (cls_q[2:1] == 2'b00);
   assign ls_cls = (cls_q[2:1] == 2'b01);
   assign br_cls = (cls_q == 3'b101);

   assign valid       = valid_q;
   assign opcode      = opcode_q;
   assign s_bit       = s_bit_q;
   assign rn          = rn_q;
   assign rd          = rd_q;
   assign rs          = rs_q;
   assign rm          = rm_q;
   assign is_dp       = dp_cls;
   assign is_ls       = ls_cls;
   assign is_branch   = br_cls;
   assign is_load     = is_load_q;
   assign is_byte     = is_byte_q;
   assign pre_index   = pre_index_q;
   assign add_offset  = add_offset_q;
   assign write_back  = write_back_q;
   assign offset_12   = offset_12_q;
   assign branch_link = link_q;
   assign imm24       = imm24_q;
   assign mem_read    = ls_cls & is_load_q;
   assign mem_write   = ls_cls & ~is_load_q;

   // ---------------------------------------------------------------------
   // Barrel shifter
   // ---------------------------------------------------------------------
   logic [4:0]  sh_imm_amt;
   logic [1:0]  sh_type;
   logic        sh_by_reg;
   logic [4:0]  imm_rot;
   logic [31:0] imm_val;
   logic [7:0]  amt;
   logic        use_rrx;
   logic [32:0] lsl_w;
   logic [32:0] lsr_w;
   logic [32:0] asr_w;
   logic [31:0] ror_val;
   logic [31:0] shift_val;
   logic        shift_c;
   logic        c_in;
   logic        unused_rs_hi;

   assign sh_imm_amt   = sh_ctl_q[7:3];
   assign sh_type      = sh_ctl_q[2:1];
   assign sh_by_reg    = sh_ctl_q[0];
   assign c_in         = flags_in[1];
   assign unused_rs_hi = ^rs_data[31:8];

   // Rotated 8-bit immediate; the rotate amount is twice the 4-bit field.
   assign imm_rot = {rs_q, 1'b0};
   assign imm_val = ({24'd0, sh_ctl_q[3:0], rm_q} >> imm_rot)
                  | ({24'd0, sh_ctl_q[3:0], rm_q} << (6'd32 - {1'b0, imm_rot}));

   // Shift amount selection, mapping the immediate "n=0" encodings to their
   // 32-bit / RRX meanings so a single shift datapath serves both forms.
   always_comb begin
      use_rrx = 1'b0;
      amt     = 8'd0;
      if (sh_by_reg) begin
         amt = rs_data[7:0];
      end else if (sh_imm_amt == 5'd0) begin
         case (sh_type)
            SH_LSL:  amt = 8'd0;
            SH_LSR:  amt = 8'd32;
            SH_ASR:  amt = 8'd32;
            default: use_rrx = 1'b1;
         endcase
      end else begin
         amt = {3'd0, sh_imm_amt};
      end
   end

   // Extra bit on each shift catches the last bit shifted out as the carry.
   assign lsl_w   = {1'b0, rm_data} << amt;
   assign lsr_w   = {rm_data, 1'b0} >> amt;
   assign asr_w   = $signed({rm_data, 1'b0}) >>> amt;
   assign ror_val = (rm_data >> amt[4:0]) | (rm_data << (6'd32 - {1'b0, amt[4:0]}));

   // Operand 2 and shifter carry-out
   always_comb begin
      shift_val = rm_data;
      shift_c   = c_in;
      if (dp_cls && cls_q[0]) begin
         shift_val = imm_val;
         shift_c   = (imm_rot == 5'd0) ? c_in : imm_val[31];
      end else if (use_rrx) begin
         shift_val = {c_in, rm_data[31:1]};
         shift_c   = rm_data[0];
      end else if (amt != 8'd0) begin
         case (sh_type)
            SH_LSL: begin
               shift_val = lsl_w[31:0];
               shift_c   = lsl_w[32];
            end
            SH_LSR: begin
               shift_val = lsr_w[32:1];
               shift_c   = lsr_w[0];
            end
            SH_ASR: begin
               shift_val = asr_w[32:1];
               shift_c   = asr_w[0];
            end
            default: begin
               // A register rotate by a multiple of 32 leaves the value intact
               shift_val = ror_val;
               shift_c   = (amt[4:0] == 5'd0) ? rm_data[31] : ror_val[31];
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // ALU
   // ---------------------------------------------------------------------
   logic [31:0] add_x;
   logic [31:0] add_y;
   logic        add_cin;
   logic [32:0] add_sum;
   logic        is_arith;
   logic [31:0] logic_res;
   logic [31:0] alu_res;
   logic        alu_c;
   logic        alu_v;
   logic        is_test;

   // Adder operand selection: subtraction is x + ~y + carry-in so the
   // carry-out is directly the ARM "not borrow" flag.
   always_comb begin
      add_x    = rn_data;
      add_y    = shift_val;
      add_cin  = 1'b0;
      is_arith = 1'b1;
      case (opcode_q)
         4'd2, 4'd10: begin add_x = rn_data;   add_y = ~shift_val; add_cin = 1'b1; end
         4'd3:        begin add_x = shift_val; add_y = ~rn_data;   add_cin = 1'b1; end
         4'd4, 4'd11: begin add_x = rn_data;   add_y = shift_val;  add_cin = 1'b0; end
         4'd5:        begin add_x = rn_data;   add_y = shift_val;  add_cin = c_in; end
         4'd6:        begin add_x = rn_data;   add_y = ~shift_val; add_cin = c_in; end
         4'd7:        begin add_x = shift_val; add_y = ~rn_data;   add_cin = c_in; end
         default:     is_arith = 1'b0;
      endcase
   end

   assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

   // Logical operation results
   always_comb begin
      logic_res = rn_data & shift_val;
      case (opcode_q)
         4'd1, 4'd9: logic_res = rn_data ^ shift_val;
         4'd12:      logic_res = rn_data | shift_val;
         4'd13:      logic_res = shift_val;
         4'd14:      logic_res = rn_data & ~shift_val;
         4'd15:      logic_res = ~shift_val;
         default:    logic_res = rn_data & shift_val;
      endcase
   end

   // Result mux and flag generation
   always_comb begin
      if (is_arith) begin
         alu_res = add_sum[31:0];
         alu_c   = add_sum[32];
         alu_v   = (add_x[31] == add_y[31]) && (add_sum[31] != add_x[31]);
      end else begin
         alu_res = logic_res;
         alu_c   = shift_c;
         alu_v   = flags_in[0];
      end
   end

   assign is_test  = (opcode_q[3:2] == 2'b10);
   assign result   = dp_cls ? alu_res : rn_data;
   assign rd_we    = dp_cls & ~is_test;
   assign flags_we = dp_cls & (s_bit_q | is_test);
   assign flags_out = flags_we ? {alu_res[31], (alu_res == 32'd0), alu_c, alu_v} : flags_in;

endmodule

// File: tb/tb_arm_exec_unit.sv
// Scoreboard bench for arm_exec_unit: directed instructions push their
// hand-computed response; a monitor checks every cycle in which valid is high.
module tb_arm_exec_unit;

   logic        clk;
   logic        n_reset;
   logic        decode_en;
   logic [31:0] instruction;
   logic [31:0] rn_data;
   logic [31:0] rm_data;
   logic [31:0] rs_data;
   logic [3:0]  flags_in;
   logic        valid;
   logic [3:0]  opcode;
   logic [3:0]  rd;
   logic [3:0]  rn;
   logic [3:0]  rm;
   logic [3:0]  rs;
   logic        s_bit;
   logic        is_dp;
   logic        is_ls;
   logic        is_branch;
   logic        is_load;
   logic        is_byte;
   logic        pre_index;
   logic        add_offset;
   logic        write_back;
   logic [11:0] offset_12;
   logic        branch_link;
   logic [23:0] imm24;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] result;
   logic        rd_we;
   logic [3:0]  flags_out;
   logic        flags_we;

   arm_exec_unit dut (
      .clk(clk), .n_reset(n_reset), .decode_en(decode_en), .instruction(instruction),
      .rn_data(rn_data), .rm_data(rm_data), .rs_data(rs_data), .flags_in(flags_in),
      .valid(valid), .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .rs(rs), .s_bit(s_bit),
      .is_dp(is_dp), .is_ls(is_ls), .is_branch(is_branch), .is_load(is_load),
      .is_byte(is_byte), .pre_index(pre_index), .add_offset(add_offset),
      .write_back(write_back), .offset_12(offset_12), .branch_link(branch_link),
      .imm24(imm24), .mem_read(mem_read), .mem_write(mem_write), .result(result),
      .rd_we(rd_we), .flags_out(flags_out), .flags_we(flags_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        rd_we;
      logic        flags_we;
      logic [3:0]  flags;
      logic [10:0] cls;
      logic [3:0]  rd;
      logic        ext;
      logic [11:0] off;
      logic [23:0] imm;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   // class vector: {dp,ls,br,load,byte,pre,add,wb,link,mem_read,mem_write}
   localparam logic [10:0] C_DP  = 11'b100_0000_0000;
   localparam logic [10:0] C_LDR = 11'b010_1011_0010;
   localparam logic [10:0] C_BL  = 11'b001_0000_0100;
   localparam logic [10:0] C_NONE = 11'b000_0000_0000;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: compare each valid cycle against the oldest expectation
   always @(negedge clk) begin
      if (n_reset && valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".result"}, {32'd0, result}, {32'd0, e.res});
            chk({e.name, ".we_flags"}, {58'd0, rd_we, flags_we, flags_out},
                {58'd0, e.rd_we, e.flags_we, e.flags});
            chk({e.name, ".class_rd"},
                {49'd0, is_dp, is_ls, is_branch, is_load, is_byte, pre_index, add_offset,
                 write_back, branch_link, mem_read, mem_write, rd},
                {49'd0, e.cls, e.rd});
            if (e.ext)
               chk({e.name, ".off_imm"}, {28'd0, offset_12, imm24}, {28'd0, e.off, e.imm});
            $display("txn %-10s result=%h flags_out=%b rd_we=%b flags_we=%b",
                     e.name, result, flags_out, rd_we, flags_we);
         end
      end
   end

   task automatic issue(input bit wait_edge, input string nm, input logic [31:0] ir,
                        input logic [31:0] rnv, input logic [31:0] rmv, input logic [31:0] rsv,
                        input logic [3:0] fl, input logic [31:0] eres, input logic ewe,
                        input logic efwe, input logic [3:0] efl, input logic [10:0] ecls,
                        input logic [3:0] erd, input logic eext, input logic [11:0] eoff,
                        input logic [23:0] eimm);
      exp_t e;
      if (wait_edge) begin
         @(posedge clk);
         #1;
      end
      instruction = ir;
      rn_data     = rnv;
      rm_data     = rmv;
      rs_data     = rsv;
      flags_in    = fl;
      decode_en   = 1'b1;
      e.name = nm; e.res = eres; e.rd_we = ewe; e.flags_we = efwe; e.flags = efl;
      e.cls = ecls; e.rd = erd; e.ext = eext; e.off = eoff; e.imm = eimm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      decode_en = 1'b0;
   endtask

   initial begin
      n_reset     = 1'b0;
      decode_en   = 1'b0;
      instruction = 32'd0;
      rn_data     = 32'd0;
      rm_data     = 32'd0;
      rs_data     = 32'd0;
      flags_in    = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.valid", {63'd0, valid}, 64'd0);
      chk("reset.opcode_dp", {59'd0, opcode, is_dp}, {59'd0, 4'd0, 1'b1});
      n_reset = 1'b1;

      //    wait name       instr         rn           rm           rs     flags    result       we fwe flo      class  rd ext off imm
      issue(1, "add",     32'hE2811005, 32'd10,      32'd0,       32'd0,  4'b0000, 32'd15,      1, 0, 4'b0000, C_DP, 1, 0, 0, 0);
      issue(1, "mov_imm", 32'hE3A004FF, 32'd0,       32'd0,       32'd0,  4'b0000, 32'hFF000000, 1, 0, 4'b0000, C_DP, 0, 0, 0, 0);
      issue(1, "subs",    32'hE0532004, 32'd5,       32'd5,       32'd0,  4'b0000, 32'd0,       1, 1, 4'b0110, C_DP, 2, 0, 0, 0);
      issue(1, "cmp",     32'hE1500001, 32'h80000000, 32'd1,      32'd0,  4'b0000, 32'h7FFFFFFF, 0, 1, 4'b0011, C_DP, 0, 0, 0, 0);
      issue(1, "lsr0",    32'hE1B00021, 32'd0,       32'h80000001, 32'd0, 4'b0000, 32'd0,       1, 1, 4'b0110, C_DP, 0, 0, 0, 0);
      issue(1, "rrx",     32'hE1A00060, 32'd0,       32'd2,       32'd0,  4'b0010, 32'h80000001, 1, 0, 4'b0010, C_DP, 0, 0, 0, 0);
      issue(1, "lslr40",  32'hE1B00211, 32'd0,       32'hFFFFFFFF, 32'd40, 4'b0010, 32'd0,      1, 1, 4'b0100, C_DP, 0, 0, 0, 0);
      issue(1, "lsl4",    32'hE1B00201, 32'd0,       32'hF0000001, 32'd0, 4'b0010, 32'h10,      1, 1, 4'b0010, C_DP, 0, 0, 0, 0);
      issue(1, "ror8",    32'hE1B00461, 32'd0,       32'h12345678, 32'd0, 4'b0011, 32'h78123456, 1, 1, 4'b0001, C_DP, 0, 0, 0, 0);
      issue(1, "asrr33",  32'hE1B00251, 32'd0,       32'h80000000, 32'd33, 4'b0000, 32'hFFFFFFFF, 1, 1, 4'b1010, C_DP, 0, 0, 0, 0);
      issue(1, "rorr32",  32'hE1B00271, 32'd0,       32'h80000000, 32'd32, 4'b0000, 32'h80000000, 1, 1, 4'b1010, C_DP, 0, 0, 0, 0);
      issue(1, "lsrr32",  32'hE1B00231, 32'd0,       32'h80000001, 32'd32, 4'b0000, 32'd0,      1, 1, 4'b0110, C_DP, 0, 0, 0, 0);
      issue(1, "adcs",    32'hE0B10002, 32'hFFFFFFFF, 32'd0,      32'd0,  4'b0010, 32'd0,       1, 1, 4'b0110, C_DP, 0, 0, 0, 0);
      issue(1, "sbcs",    32'hE0D10002, 32'd5,       32'd3,       32'd0,  4'b0000, 32'd1,       1, 1, 4'b0010, C_DP, 0, 0, 0, 0);
      issue(1, "rsbs",    32'hE0710002, 32'd5,       32'd3,       32'd0,  4'b0000, 32'hFFFFFFFE, 1, 1, 4'b1000, C_DP, 0, 0, 0, 0);
      issue(1, "teq",     32'hE1310002, 32'hFF,      32'hFF,      32'd0,  4'b0011, 32'd0,       0, 1, 4'b0111, C_DP, 0, 0, 0, 0);
      issue(1, "bic",     32'hE1C10002, 32'hFF,      32'h0F,      32'd0,  4'b0101, 32'hF0,      1, 0, 4'b0101, C_DP, 0, 0, 0, 0);
      issue(1, "ldr",     32'hE5912004, 32'h1000,    32'd0,       32'd0,  4'b0000, 32'h1000,    0, 0, 4'b0000, C_LDR, 2, 1, 12'd4, 24'd0);
      issue(1, "bl",      32'hEB000010, 32'h44,      32'd0,       32'd0,  4'b0000, 32'h44,      0, 0, 4'b0000, C_BL, 0, 1, 12'd0, 24'h10);
      issue(1, "undef",   32'hEC000000, 32'h77,      32'd0,       32'd0,  4'b1001, 32'h77,      0, 0, 4'b1001, C_NONE, 0, 0, 0, 0);
      // back-to-back decode: valid stays high, second edge overwrites fields
      issue(1, "b2b_add", 32'hE2811005, 32'd10,      32'd0,       32'd0,  4'b0000, 32'd15,      1, 0, 4'b0000, C_DP, 1, 0, 0, 0);
      issue(0, "b2b_mov", 32'hE3A004FF, 32'd10,      32'd0,       32'd0,  4'b0000, 32'hFF000000, 1, 0, 4'b0000, C_DP, 0, 0, 0, 0);

      // drain scoreboard with a bounded wait
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", {32'd0, sb.size()}, 64'd0);

      // asynchronous reset while valid is high (not via scoreboard)
      @(posedge clk);
      #1;
      instruction = 32'hE5912004;
      decode_en   = 1'b1;
      @(posedge clk);
      #1;
      decode_en = 1'b0;
      chk("pre_reset.valid_ls", {62'd0, valid, is_ls}, {62'd0, 2'b11});
      n_reset = 1'b0;
      #1;
      chk("async_reset.valid", {63'd0, valid}, 64'd0);
      chk("async_reset.fields", {40'd0, opcode, rd, rn, offset_12},
          {40'd0, 4'd0, 4'd0, 4'd0, 12'd0});
      chk("async_reset.class", {61'd0, is_dp, is_ls, mem_read}, {61'd0, 3'b100});
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
